// File: rtl/countdown_ctrl.sv
// countdown_ctrl: keypad entry, validation and sequencing for the MM:SS BCD countdown chain.
// Drives the chain's shared load/clear/enable controls and a tick-timed done alarm at 00:00.
module countdown_ctrl #(
  parameter int ALARM_TICKS = 10
) (
  input  logic        i_clk,
  input  logic        i_clr,
  input  logic        i_tick,
  input  logic        i_key_valid,
  input  logic [3:0]  i_key,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic        i_cancel,
  input  logic        i_cnt_zero,
  output logic [15:0] o_digits,
  output logic        o_cnt_loadn,
  output logic        o_cnt_clrn,
  output logic        o_cnt_en,
  output logic        o_running,
  output logic        o_done,
  output logic        o_err
);

  localparam int AW = ($clog2(ALARM_TICKS + 1) > 4) ? $clog2(ALARM_TICKS + 1) : 4;
  localparam logic [AW-1:0] ALARM_LOAD = AW'(ALARM_TICKS);
  localparam logic [AW-1:0] ALARM_ONE  = AW'(1);
  localparam logic [AW-1:0] ALARM_ZERO = AW'(0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_PAUSE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_digits, w_digits_nxt;
  logic [AW-1:0] r_alarm, w_alarm_nxt;
  logic          r_loadn, w_loadn_nxt;
  logic          r_clrn, w_clrn_nxt;
  logic          r_err, w_err_nxt;
  logic          r_running, r_done;
  logic          w_is_digit, w_entry_ok;

  assign w_is_digit = i_key_valid && (i_key <= 4'd9);
  // A valid entry is non-zero and has a seconds-tens digit the mod-6 counter can hold.
  assign w_entry_ok = (r_digits != 16'd0) && (r_digits[7:4] <= 4'd5);

  // Next-state, entry register, alarm counter and registered control decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_digits_nxt = r_digits;
    w_alarm_nxt  = r_alarm;
    w_loadn_nxt  = 1'b1;
    w_clrn_nxt   = 1'b1;
    w_err_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_is_digit) begin
          w_digits_nxt = {r_digits[11:0], i_key};
          w_state_nxt  = S_ENTRY;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ENTRY: begin
        if (i_cancel) begin
          w_digits_nxt = 16'd0;
          w_clrn_nxt   = 1'b0;
          w_state_nxt  = S_IDLE;
        end else if (i_start) begin
          if (w_entry_ok) begin
            w_loadn_nxt = 1'b0;
            w_state_nxt = S_LOAD;
          end else begin
            w_err_nxt = 1'b1;
          end
        end else if (w_is_digit) begin
          w_digits_nxt = {r_digits[11:0], i_key};
        end else begin
          w_state_nxt = S_ENTRY;
        end
      end
      S_LOAD: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (i_cancel) begin
          w_digits_nxt = 16'd0;
          w_clrn_nxt   = 1'b0;
          w_state_nxt  = S_IDLE;
        end else if (i_stop) begin
          w_state_nxt = S_PAUSE;
        end else if (i_cnt_zero) begin
          w_alarm_nxt = ALARM_LOAD;
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_PAUSE: begin
        if (i_cancel) begin
          w_digits_nxt = 16'd0;
          w_clrn_nxt   = 1'b0;
          w_state_nxt  = S_IDLE;
        end else if (i_start) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_PAUSE;
        end
      end
      S_DONE: begin
        // Any acknowledge ends the alarm; the key that does so is swallowed.
        if (i_cancel || i_start || i_key_valid) begin
          w_digits_nxt = 16'd0;
          w_alarm_nxt  = ALARM_ZERO;
          w_state_nxt  = S_IDLE;
        end else if (i_tick) begin
          if (r_alarm <= ALARM_ONE) begin
            w_digits_nxt = 16'd0;
            w_alarm_nxt  = ALARM_ZERO;
            w_state_nxt  = S_IDLE;
          end else begin
            w_alarm_nxt = r_alarm - ALARM_ONE;
          end
        end else if (r_alarm == ALARM_ZERO) begin
          w_digits_nxt = 16'd0;
          w_state_nxt  = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset holds the counter chain cleared.
  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_state   <= S_IDLE;
      r_digits  <= 16'd0;
      r_alarm   <= ALARM_ZERO;
      r_loadn   <= 1'b1;
      r_clrn    <= 1'b0;
      r_err     <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_digits  <= w_digits_nxt;
      r_alarm   <= w_alarm_nxt;
      r_loadn   <= w_loadn_nxt;
      r_clrn    <= w_clrn_nxt;
      r_err     <= w_err_nxt;
      r_running <= (w_state_nxt == S_RUN);
      r_done    <= (w_state_nxt == S_DONE);
    end
  end

  // Never enable at 00:00 so the chain cannot wrap; stop/cancel win over a same-cycle tick.
  assign o_cnt_en    = (r_state == S_RUN) && i_tick && !i_cnt_zero && !i_stop && !i_cancel;
  assign o_digits    = r_digits;
  assign o_cnt_loadn = r_loadn;
  assign o_cnt_clrn  = r_clrn;
  assign o_running   = r_running;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Self-checking bench for countdown_ctrl: directed scenarios plus randomized strobes
// compared against a seconds-remaining model of the counter chain and a behavioural controller model.
module tb_countdown_ctrl;

  localparam int ALARM = 3;
  localparam int M_IDLE = 0, M_ENTRY = 1, M_LOAD = 2, M_RUN = 3, M_PAUSE = 4, M_DONE = 5;

  logic        clk = 1'b0;
  logic        clr, tick, key_valid, start, stop, cancel, cnt_zero;
  logic [3:0]  key;
  logic [15:0] digits;
  logic        cnt_loadn, cnt_clrn, cnt_en, running, done, err;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   dp_secs = 0;
  int   en_pulses = 0;
  logic obs_en;

  int   m_mode;
  int   m_dig[4];
  int   m_done_ticks;
  logic e_err, e_loadn, e_clrn, e_en;

  countdown_ctrl #(.ALARM_TICKS(ALARM)) dut (
    .i_clk       (clk),
    .i_clr       (clr),
    .i_tick      (tick),
    .i_key_valid (key_valid),
    .i_key       (key),
    .i_start     (start),
    .i_stop      (stop),
    .i_cancel    (cancel),
    .i_cnt_zero  (cnt_zero),
    .o_digits    (digits),
    .o_cnt_loadn (cnt_loadn),
    .o_cnt_clrn  (cnt_clrn),
    .o_cnt_en    (cnt_en),
    .o_running   (running),
    .o_done      (done),
    .o_err       (err)
  );

  always #5 clk = ~clk;

  // The counter chain seen as total seconds left; wraps 00:00 -> 99:59 like the real chain.
  always @(posedge clk or negedge cnt_clrn) begin
    if (!cnt_clrn)
      dp_secs <= 0;
    else if (!cnt_loadn)
      dp_secs <= 600 * int'(digits[15:12]) + 60 * int'(digits[11:8])
               + 10 * int'(digits[7:4]) + int'(digits[3:0]);
    else if (cnt_en)
      dp_secs <= (dp_secs == 0) ? 5999 : dp_secs - 1;
  end
  assign cnt_zero = (dp_secs == 0);

  always @(posedge clk) begin
    if (cnt_en) en_pulses <= en_pulses + 1;
  end

  function automatic logic [15:0] m_pack();
    return 16'(m_dig[0] * 4096 + m_dig[1] * 256 + m_dig[2] * 16 + m_dig[3]);
  endfunction

  task automatic m_clear_digits();
    for (int i = 0; i < 4; i++) m_dig[i] = 0;
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_clear_digits();
    m_done_ticks = 0;
    e_err = 1'b0; e_loadn = 1'b1; e_clrn = 1'b0; e_en = 1'b0;
  endtask

  // Advance the controller model across one clock edge using the inputs now applied.
  task automatic model_edge();
    bit is_digit;
    is_digit = key_valid && (int'(key) < 10);
    if (clr) begin
      model_reset();
      return;
    end
    e_en = (m_mode == M_RUN) && tick && !cnt_zero && !stop && !cancel;
    e_err = 1'b0; e_loadn = 1'b1; e_clrn = 1'b1;
    if (cancel && (m_mode == M_ENTRY || m_mode == M_RUN || m_mode == M_PAUSE)) begin
      m_clear_digits();
      e_clrn = 1'b0;
      m_mode = M_IDLE;
    end else if (m_mode == M_IDLE || m_mode == M_ENTRY) begin
      if (m_mode == M_ENTRY && start) begin
        if (m_dig[0] + m_dig[1] + m_dig[2] + m_dig[3] == 0 || m_dig[2] > 5) e_err = 1'b1;
        else begin e_loadn = 1'b0; m_mode = M_LOAD; end
      end else if (is_digit) begin
        m_dig[0] = m_dig[1]; m_dig[1] = m_dig[2]; m_dig[2] = m_dig[3]; m_dig[3] = int'(key);
        m_mode = M_ENTRY;
      end
    end else if (m_mode == M_LOAD) begin
      m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (stop) m_mode = M_PAUSE;
      else if (cnt_zero) begin m_mode = M_DONE; m_done_ticks = 0; end
    end else if (m_mode == M_PAUSE) begin
      if (start) m_mode = M_RUN;
    end else if (m_mode == M_DONE) begin
      if (cancel || start || key_valid) begin m_clear_digits(); m_mode = M_IDLE; end
      else if (tick) begin
        m_done_ticks++;
        if (m_done_ticks >= ALARM) begin m_clear_digits(); m_mode = M_IDLE; end
      end
    end
  endtask

  // Apply current inputs across one edge; leaves time at edge+1 with strobes released.
  task automatic step();
    #1;
    obs_en = cnt_en;
    model_edge();
    @(posedge clk);
    #1;
    tick = 1'b0; key_valid = 1'b0; start = 1'b0; stop = 1'b0; cancel = 1'b0; key = 4'd0;
  endtask

  task automatic press(input int k);
    key = 4'(k);
    key_valid = 1'b1;
    step();
  endtask

  task automatic test_reset();
    clr = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    n_tests++;
    if ({digits, cnt_loadn, cnt_clrn, cnt_en, running, done, err} !== {16'h0000, 6'b100000}) begin
      n_fail++;
      $display("FAIL reset_values got %h/%b%b%b%b%b%b want 0000/100000", digits,
               cnt_loadn, cnt_clrn, cnt_en, running, done, err);
    end
    clr = 1'b0;
    #1;
    n_tests++;
    if (cnt_clrn !== 1'b0) begin n_fail++; $display("FAIL clrn_before_edge got %b want 0", cnt_clrn); end
    step();
    n_tests++;
    if (cnt_clrn !== 1'b1) begin n_fail++; $display("FAIL clrn_after_edge got %b want 1", cnt_clrn); end
  endtask

  task automatic test_keypad();
    press(1); press(2); press(3); press(4);
    n_tests++;
    if (digits !== 16'h1234 || running !== 1'b0) begin
      n_fail++; $display("FAIL keypad_1234 got %h run=%b want 1234 run=0", digits, running);
    end
    press(5);
    n_tests++;
    if (digits !== 16'h2345) begin n_fail++; $display("FAIL keypad_shift got %h want 2345", digits); end
    press(12);
    n_tests++;
    if (digits !== 16'h2345) begin n_fail++; $display("FAIL keypad_nondigit got %h want 2345", digits); end
  endtask

  task automatic test_validation();
    cancel = 1'b1; step();
    n_tests++;
    if (cnt_clrn !== 1'b0 || digits !== 16'h0000) begin
      n_fail++; $display("FAIL entry_cancel got clrn=%b dig=%h want 0/0000", cnt_clrn, digits);
    end
    step();
    n_tests++;
    if (cnt_clrn !== 1'b1) begin n_fail++; $display("FAIL cancel_pulse_width got %b want 1", cnt_clrn); end
    press(0); press(0); press(7); press(0);
    start = 1'b1; step();
    n_tests++;
    if (err !== 1'b1 || cnt_loadn !== 1'b1) begin
      n_fail++; $display("FAIL reject_sec_t got err=%b loadn=%b want 1/1", err, cnt_loadn);
    end
    step();
    n_tests++;
    if (err !== 1'b0 || cnt_loadn !== 1'b1 || running !== 1'b0 || digits !== 16'h0070) begin
      n_fail++; $display("FAIL err_width got err=%b loadn=%b run=%b dig=%h want 0/1/0/0070",
                         err, cnt_loadn, running, digits);
    end
    cancel = 1'b1; step();
    press(0); press(0); press(0); press(0);
    start = 1'b1; step();
    n_tests++;
    if (err !== 1'b1 || cnt_loadn !== 1'b1) begin
      n_fail++; $display("FAIL reject_zero got err=%b loadn=%b want 1/1", err, cnt_loadn);
    end
    cancel = 1'b1; step();
  endtask

  task automatic test_load_count_alarm();
    int base;
    press(0); press(1); press(0); press(5);
    base = en_pulses;
    start = 1'b1; step();
    n_tests++;
    if (cnt_loadn !== 1'b0 || running !== 1'b0) begin
      n_fail++; $display("FAIL load_pulse got loadn=%b run=%b want 0/0", cnt_loadn, running);
    end
    step();
    n_tests++;
    if (cnt_loadn !== 1'b1 || running !== 1'b1 || dp_secs != 65) begin
      n_fail++; $display("FAIL load_to_run got loadn=%b run=%b secs=%0d want 1/1/65", cnt_loadn, running, dp_secs);
    end
    for (int c = 0; c < 400 && done !== 1'b1; c++) begin
      tick = (c % 3 == 0);
      step();
    end
    n_tests++;
    if (done !== 1'b1 || en_pulses - base != 65 || digits !== 16'h0105) begin
      n_fail++; $display("FAIL count_to_done got done=%b en=%0d dig=%h want 1/65/0105", done, en_pulses - base, digits);
    end
    tick = 1'b1; step(); tick = 1'b1; step();
    n_tests++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL alarm_hold got done=%b want 1", done); end
    tick = 1'b1; step();
    n_tests++;
    if (done !== 1'b0 || digits !== 16'h0000 || running !== 1'b0 || en_pulses - base != 65) begin
      n_fail++; $display("FAIL alarm_expire got done=%b dig=%h en=%0d want 0/0000/65", done, digits, en_pulses - base);
    end
  endtask

  task automatic test_pause_cancel();
    int base;
    press(0); press(0); press(3); press(0);
    start = 1'b1; step(); step();
    base = en_pulses;
    tick = 1'b1; step(); tick = 1'b1; step();
    stop = 1'b1; tick = 1'b1; step();
    n_tests++;
    if (obs_en !== 1'b0 || running !== 1'b0) begin
      n_fail++; $display("FAIL stop_with_tick got en=%b run=%b want 0/0", obs_en, running);
    end
    for (int i = 0; i < 3; i++) begin tick = 1'b1; step(); end
    n_tests++;
    if (en_pulses - base != 2 || dp_secs != 28) begin
      n_fail++; $display("FAIL pause_hold got en=%0d secs=%0d want 2/28", en_pulses - base, dp_secs);
    end
    start = 1'b1; tick = 1'b1; step();
    n_tests++;
    if (obs_en !== 1'b0 || running !== 1'b1) begin
      n_fail++; $display("FAIL resume_with_tick got en=%b run=%b want 0/1", obs_en, running);
    end
    tick = 1'b1; step();
    n_tests++;
    if (obs_en !== 1'b1 || dp_secs != 27) begin
      n_fail++; $display("FAIL resume_tick got en=%b secs=%0d want 1/27", obs_en, dp_secs);
    end
    stop = 1'b1; step();
    cancel = 1'b1; step();
    n_tests++;
    if (cnt_clrn !== 1'b0 || digits !== 16'h0000 || running !== 1'b0 || dp_secs != 0) begin
      n_fail++; $display("FAIL pause_cancel got clrn=%b dig=%h run=%b secs=%0d want 0/0000/0/0",
                         cnt_clrn, digits, running, dp_secs);
    end
    step();
    n_tests++;
    if (cnt_clrn !== 1'b1) begin n_fail++; $display("FAIL pause_cancel_width got %b want 1", cnt_clrn); end
  endtask

  task automatic test_done_key();
    press(0); press(0); press(0); press(2);
    start = 1'b1; step(); step();
    for (int c = 0; c < 50 && done !== 1'b1; c++) begin
      tick = (c % 2 == 0);
      step();
    end
    n_tests++;
    if (done !== 1'b1 || digits !== 16'h0002) begin
      n_fail++; $display("FAIL short_run_done got done=%b dig=%h want 1/0002", done, digits);
    end
    press(7);
    n_tests++;
    if (done !== 1'b0 || digits !== 16'h0000) begin
      n_fail++; $display("FAIL done_key_exit got done=%b dig=%h want 0/0000", done, digits);
    end
  endtask

  task automatic test_clr_mid_run();
    press(0); press(0); press(2); press(0);
    start = 1'b1; step(); step();
    tick = 1'b1; step(); tick = 1'b1; step();
    clr = 1'b1; tick = 1'b1;
    #1;
    n_tests++;
    if ({digits, cnt_loadn, cnt_clrn, cnt_en, running, done, err} !== {16'h0000, 6'b100000}) begin
      n_fail++; $display("FAIL clr_async got %h/%b%b%b%b%b%b want 0000/100000", digits,
                         cnt_loadn, cnt_clrn, cnt_en, running, done, err);
    end
    model_reset();
    step(); step();
    n_tests++;
    if (cnt_clrn !== 1'b0 || dp_secs != 0) begin
      n_fail++; $display("FAIL clr_hold got clrn=%b secs=%0d want 0/0", cnt_clrn, dp_secs);
    end
    clr = 1'b0;
    #1;
    n_tests++;
    if (cnt_clrn !== 1'b0) begin n_fail++; $display("FAIL clr_release_pre got %b want 0", cnt_clrn); end
    step();
    n_tests++;
    if (cnt_clrn !== 1'b1 || running !== 1'b0) begin
      n_fail++; $display("FAIL clr_release_post got clrn=%b run=%b want 1/0", cnt_clrn, running);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      clr       = ($urandom_range(0, 299) == 0);
      tick      = ($urandom_range(0, 3) == 0);
      key_valid = ($urandom_range(0, 3) == 0);
      key       = 4'($urandom_range(0, 15));
      start     = ($urandom_range(0, 11) == 0);
      stop      = ($urandom_range(0, 19) == 0);
      cancel    = ($urandom_range(0, 39) == 0);
      step();
      n_tests++;
      if ({digits, running, done, err, cnt_loadn, cnt_clrn} !==
          {m_pack(), m_mode == M_RUN, m_mode == M_DONE, e_err, e_loadn, e_clrn}) begin
        n_fail++;
        $display("FAIL random_outputs cycle %0d got %h/%b%b%b%b%b want %h/%b%b%b%b%b", i,
                 digits, running, done, err, cnt_loadn, cnt_clrn,
                 m_pack(), m_mode == M_RUN, m_mode == M_DONE, e_err, e_loadn, e_clrn);
      end
      n_tests++;
      if (obs_en !== e_en) begin
        n_fail++; $display("FAIL random_cnt_en cycle %0d got %b want %b", i, obs_en, e_en);
      end
    end
    clr = 1'b0;
  endtask

  initial begin
    clr = 1'b1; tick = 1'b0; key_valid = 1'b0; key = 4'd0;
    start = 1'b0; stop = 1'b0; cancel = 1'b0; obs_en = 1'b0;
    model_reset();
    test_reset();
    test_keypad();
    test_validation();
    test_load_count_alarm();
    test_pause_cancel();
    test_done_key();
    test_clr_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
